// File: rtl/mips32_prog_loader.sv
// mips32_prog_loader: byte-stream program loader for the MIPS32 1024 x 32 memory.
// Receives framed bytes over a valid/ready link, assembles big-endian words,
// issues one memory write per word and holds the CPU while a frame is in flight.
// Frame: MAGIC, count hi/lo, base hi/lo, count*4 data bytes (MSB first), checksum.
// The checksum is the XOR of every byte after MAGIC, up to but not including itself.
// Optional feature macro: LOADER_TIMEOUT_EN. When it is defined, a frame that
// stalls mid-way for TIMEOUT_CYC cycles is aborted with err set.
module mips32_prog_loader #(
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] MAGIC       = 8'hA5,
  parameter int         TIMEOUT_CYC = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_cnt
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CNT_H   = 3'd1,
    CNT_L   = 3'd2,
    ADR_H   = 3'd3,
    ADR_L   = 3'd4,
    DATA    = 3'd5,
    CSUM    = 3'd6,
    DONE_ST = 3'd7
  } state_t;

  state_t            state_r;
  logic [15:0]       count_r;
  logic [7:0]        base_hi_r;
  logic [ADDR_W-1:0] base_r;
  logic [23:0]       word_r;     // first three bytes of the word being assembled
  logic [1:0]        byte_idx_r;
  logic [7:0]        csum_r;
  logic              accept_s;
  logic              timeout_s;

  // Running XOR checksum update.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  assign accept_s = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  logic [IDLE_W-1:0] idle_cnt_r;

  // Abort request: this cycle is the TIMEOUT_CYC-th consecutive mid-frame cycle without a byte.
  always_comb begin
    timeout_s = 1'b0;
    if ((state_r != IDLE) && (state_r != DONE_ST) && !accept_s &&
        (idle_cnt_r == IDLE_W'(TIMEOUT_CYC - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Count mid-frame cycles without an accepted byte; cleared on any accept or abort.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_r <= '0;
    end else if ((state_r == IDLE) || (state_r == DONE_ST) || accept_s || timeout_s) begin
      idle_cnt_r <= '0;
    end else begin
      idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
    end
  end
`else
  // Timeout compiled out: the comparison below is always false.
  assign timeout_s = (TIMEOUT_CYC < 0);
`endif

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      in_ready   <= 1'b1;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'h0000_0000;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      word_cnt   <= 16'h0000;
      count_r    <= 16'h0000;
      base_hi_r  <= 8'h00;
      base_r     <= '0;
      word_r     <= 24'h00_0000;
      byte_idx_r <= 2'd0;
      csum_r     <= 8'h00;
    end else begin
      // Strobes default low; in_ready is only dropped for the single DONE_ST cycle.
      mem_we   <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b1;
      if (timeout_s) begin
        // Stalled frame: drop any partial word, release the CPU and flag the error.
        err        <= 1'b1;
        cpu_hold   <= 1'b0;
        byte_idx_r <= 2'd0;
        state_r    <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (accept_s && (in_data == MAGIC)) begin
              cpu_hold <= 1'b1;
              err      <= 1'b0;
              word_cnt <= 16'h0000;
              csum_r   <= 8'h00;
              state_r  <= CNT_H;
            end else begin
              state_r <= IDLE;
            end
          end
          CNT_H: begin
            if (accept_s) begin
              count_r[15:8] <= in_data;
              csum_r        <= csum_next(csum_r, in_data);
              state_r       <= CNT_L;
            end else begin
              state_r <= CNT_H;
            end
          end
          CNT_L: begin
            if (accept_s) begin
              count_r[7:0] <= in_data;
              csum_r       <= csum_next(csum_r, in_data);
              state_r      <= ADR_H;
            end else begin
              state_r <= CNT_L;
            end
          end
          ADR_H: begin
            if (accept_s) begin
              base_hi_r <= in_data;
              csum_r    <= csum_next(csum_r, in_data);
              state_r   <= ADR_L;
            end else begin
              state_r <= ADR_H;
            end
          end
          ADR_L: begin
            if (accept_s) begin
              // Base is truncated to the memory address width.
              base_r     <= ADDR_W'({base_hi_r, in_data});
              csum_r     <= csum_next(csum_r, in_data);
              byte_idx_r <= 2'd0;
              if (count_r == 16'h0000) begin
                state_r <= CSUM;
              end else begin
                state_r <= DATA;
              end
            end else begin
              state_r <= ADR_L;
            end
          end
          DATA: begin
            if (accept_s) begin
              csum_r     <= csum_next(csum_r, in_data);
              byte_idx_r <= byte_idx_r + 2'd1;
              if (byte_idx_r == 2'd3) begin
                // Fourth byte completes the word: write it the very next cycle.
                mem_we    <= 1'b1;
                mem_wdata <= {word_r, in_data};
                mem_addr  <= base_r + word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + 16'd1;
                if ((word_cnt + 16'd1) == count_r) begin
                  state_r <= CSUM;
                end else begin
                  state_r <= DATA;
                end
              end else begin
                word_r  <= {word_r[15:0], in_data};
                state_r <= DATA;
              end
            end else begin
              state_r <= DATA;
            end
          end
          CSUM: begin
            if (accept_s) begin
              // Words already written stay written whatever the checksum says.
              cpu_hold <= 1'b0;
              if (in_data == csum_r) begin
                done     <= 1'b1;
                in_ready <= 1'b0;
                state_r  <= DONE_ST;
              end else begin
                err     <= 1'b1;
                state_r <= IDLE;
              end
            end else begin
              state_r <= CSUM;
            end
          end
          DONE_ST: begin
            state_r <= IDLE;
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mips32_prog_loader.md
Name: mips32_prog_loader

Overview:
- Byte-stream program loader that writes 32-bit instruction/data words into the MIPS32 1024 x 32 memory array.
- It is the writer side of the memory that the pipeline's IF and MEM stages read.
- Accepts framed bytes from a host link over a valid/ready handshake and assembles big-endian words. Issues one write per word and holds the processor (cpu_hold) while a frame is in progress.
- Sits between the host/debug link and the memory write port; replaces testbench backdoor loading of Mem[].

Parameters:
- ADDR_W, 10, memory word-address width; addresses wrap modulo 2^ADDR_W.
- MAGIC, 8'hA5, frame start byte.
- TIMEOUT_CYC, 1000, idle cycles mid-frame before abort (used only with LOADER_TIMEOUT_EN).

Ports:
- clk  input  1  single system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader can accept a byte.
- mem_we  output  1  one-cycle memory write strobe.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  word to write.
- cpu_hold  output  1  high while a frame is being received; processor must not fetch.
- done  output  1  one-cycle pulse: frame completed, checksum good.
- err  output  1  sticky: last frame had a bad checksum or timed out; cleared on next MAGIC accept or rst.
- word_cnt  output  16  words written in current/last frame.

Behaviour:
- Clock and reset: single clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, err=0, word_cnt=0.
- Handshake: a byte is accepted on a posedge with in_valid&&in_ready. in_ready=1 in every state except DONE_ST (one cycle). in_data is ignored when in_valid=0.
- Frame format, in order: MAGIC; count hi; count lo; base hi; base lo; count x 4 data bytes (MSB first); checksum.
  - count and base are 16 bits.
  - base is truncated to ADDR_W bits.
  - The checksum is the XOR of all bytes after MAGIC, excluding the checksum itself.
- States: IDLE -> CNT_H -> CNT_L -> ADR_H -> ADR_L -> DATA -> CSUM -> DONE_ST -> IDLE.
- IDLE:
  - Non-MAGIC bytes are consumed and discarded.
  - On MAGIC: cpu_hold<=1, err<=0, word_cnt<=0, xor accumulator<=0.
- ADR_L:
  - If count==0, go to CSUM; otherwise go to DATA with byte index 0.
- DATA:
  - Shift bytes into the word register.
  - On acceptance of byte index 3, the next cycle drives: mem_we=1, mem_wdata=assembled word, mem_addr=base+word_cnt (mod 2^ADDR_W).
  - word_cnt increments in that same cycle.
  - Back-to-back bytes at full rate (one per cycle) are supported with no stalls.
- CSUM:
  - If the received byte equals the accumulator: go to DONE_ST, with done=1 for one cycle and cpu_hold<=0.
  - On mismatch: err<=1, cpu_hold<=0, return to IDLE with no done pulse.
  - Words already written are not rolled back.
- DONE_ST: in_ready=0 for one cycle, then return to IDLE.
- Latency: last data byte accepted -> mem_we one cycle later. Checksum byte accepted -> done one cycle later.
- Address wrap: base=1023 with count=2 writes addresses 1023 then 0.
- MAGIC in mid-frame: treated as ordinary data; no resync.
- rst mid-frame: frame is abandoned, all outputs return to reset values, and no further writes occur.
- mem_we is never asserted in any state other than the cycle after a completed word.

Optional Feature:
- Macro: LOADER_TIMEOUT_EN.
- Defined:
  - An idle counter counts cycles without an accepted byte in any state other than IDLE/DONE_ST. It resets on each accept.
  - On reaching TIMEOUT_CYC: err<=1, cpu_hold<=0, state<=IDLE, and any partial word is discarded (no write).
- Not defined: no counter is present, and a stalled frame holds cpu_hold indefinitely until rst or frame completion.

Test Plan:
- Load program: bytes A5 00 02 00 00 28 01 00 0A 28 02 00 14, checksum = XOR of bytes after A5 -> mem_we at addr 0 with 2801000A, addr 1 with 28020014. done pulse, word_cnt=2, cpu_hold low after done, err=0.
- Bad checksum: same frame with final byte XOR 01 -> both writes occur, no done pulse, err=1, cpu_hold=0. A following good frame clears err on its A5.
- Zero count and garbage: bytes 00 FF then A5 00 00 00 78 78 -> garbage discarded, no mem_we, done pulse.
- Wrap and backpressure: base 03FF, count 2, in_valid toggled randomly -> writes to 3FF then 000 with correct words, no duplicate strobes.
- Reset mid-frame: rst asserted after 2 of 4 data bytes -> no mem_we; outputs at reset values; next full frame loads correctly.
- Timeout (LOADER_TIMEOUT_EN, TIMEOUT_CYC=20): stop after count hi byte -> err=1, cpu_hold=0 at cycle 20, state back to IDLE.
